// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
// Request fields are registered by the master and held stable while it waits for bus_ack.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_be,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_be,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns RV32I loads/stores into word-aligned bus
// transactions, formats load data for me_wb and stalls the pipeline until the bus answers.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid_i,
  input  logic                      DMWr_i,
  input  logic [2:0]                DMCtrl_i,
  input  logic [31:0]               ALURes_i,
  input  logic [31:0]               DMDataWr_i,
  mem_access_unit_if.master         bus,
  output logic [31:0]               DMDataRd_o,
  output logic                      stall_o,
  output logic                      dm_fault_o,
  output logic                      bus_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rd_q, rd_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    ctrl_q, ctrl_d;

  logic          misaligned;
  logic          illegal;
  logic          fault;
  logic [3:0]    beNext;
  logic [31:0]   wdataNext;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [31:0]   loadData;

  // Access legality is only judged when a new access would be accepted in IDLE.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (DMCtrl_i)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = ALURes_i[0];
      3'b010:         misaligned = |ALURes_i[1:0];
      default:        illegal    = 1'b1;
    endcase
    if (DMWr_i && DMCtrl_i[2]) illegal = 1'b1;
    fault = mem_valid_i && (state_q == S_IDLE) && (misaligned || illegal);
  end

  always_comb begin
    case (DMCtrl_i[1:0])
      2'b00: begin
        beNext    = 4'b0001 << ALURes_i[1:0];
        wdataNext = {4{DMDataWr_i[7:0]}};
      end
      2'b01: begin
        beNext    = 4'b0011 << ALURes_i[1:0];
        wdataNext = {2{DMDataWr_i[15:0]}};
      end
      default: begin
        beNext    = 4'b1111;
        wdataNext = DMDataWr_i;
      end
    endcase
  end

  // Lane selection uses the offset and width captured at issue, not the live pipeline inputs.
  always_comb begin
    byteSel = bus.bus_rdata[8*off_q +: 8];
    halfSel = bus.bus_rdata[16*off_q[1] +: 16];
    case (ctrl_q)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b010:  loadData = bus.bus_rdata;
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid_i) begin
          if (fault) begin
            if (!DMWr_i) rd_d = 32'd0;
          end else begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            we_d    = DMWr_i;
            addr_d  = {ALURes_i[31:2], 2'b00};
            be_d    = beNext;
            wdata_d = wdataNext;
            cnt_d   = '0;
            off_d   = ALURes_i[1:0];
            ctrl_d  = DMCtrl_i;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.bus_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) rd_d = loadData;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rd_d    = 32'd0;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      off_q   <= 2'd0;
      ctrl_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;
  assign DMDataRd_o    = rd_q;
  assign bus_err_o     = err_q;
  assign dm_fault_o    = fault;
  assign stall_o       = mem_valid_i && !fault && (state_q != S_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed spec scenarios plus randomized accesses
// compared against an arithmetic reference model of the RV32I load/store rules.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        memValid;
  logic        dmWr;
  logic [2:0]  dmCtrl;
  logic [31:0] aluRes;
  logic [31:0] dmDataWr;
  logic [31:0] dmDataRd;
  logic        stall;
  logic        dmFault;
  logic        busErr;

  int          checks;
  int          errors;
  logic [31:0] expRd;

  mem_access_unit_if busIf ();

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid_i(memValid),
    .DMWr_i     (dmWr),
    .DMCtrl_i   (dmCtrl),
    .ALURes_i   (aluRes),
    .DMDataWr_i (dmDataWr),
    .bus        (busIf),
    .DMDataRd_o (dmDataRd),
    .stall_o    (stall),
    .dm_fault_o (dmFault),
    .bus_err_o  (busErr)
  );

  // Free-running pipeline clock.
  always #5 clk = ~clk;

  // Access width in bytes, 0 when the funct3 code is not a legal load/store width.
  function automatic int sizeOf(input logic [2:0] ctrl);
    case (ctrl)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit modelFault(input bit we, input logic [2:0] ctrl, input logic [31:0] addr);
    int sz;
    sz = sizeOf(ctrl);
    if (sz == 0) return 1'b1;
    if (we && ctrl >= 3'd4) return 1'b1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] ctrl, input logic [31:0] addr);
    int sz;
    int mask;
    sz   = sizeOf(ctrl);
    mask = ((1 << sz) - 1) << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] ctrl, input logic [31:0] d);
    int sz;
    sz = sizeOf(ctrl);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] ctrl, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] v;
    int          sz;
    sz = sizeOf(ctrl);
    v  = rdata >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (ctrl == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (ctrl == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One access from IDLE; ackDelay = WAIT cycle carrying bus_ack (0 = never acknowledge).
  // Entered and left at one time unit after a rising edge.
  task automatic applyStimulus(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd, input int ackDelay);
    bit          f;
    bit          timedOut;
    bit          done;
    bit          stable;
    int          waitExp;
    int          reqCnt;
    int          stallCnt;
    logic [31:0] eAddr;
    logic [3:0]  eBe;
    logic [31:0] eWdata;

    f        = modelFault(we, ctrl, addr);
    memValid = 1'b1;
    dmWr     = we;
    dmCtrl   = ctrl;
    aluRes   = addr;
    dmDataWr = wd;
    busIf.bus_rdata = rd;
    #1;
    checkOutput("dm_fault", dmFault, f);

    if (f) begin
      checkOutput("fault_stall", stall, 1'b0);
      @(posedge clk); #1;
      if (!we) expRd = 32'd0;
      checkOutput("fault_no_req", busIf.bus_req, 1'b0);
      checkOutput("fault_rd", dmDataRd, expRd);
      memValid = 1'b0;
    end else begin
      eAddr    = addr & 32'hFFFFFFFC;
      eBe      = modelBe(ctrl, addr);
      eWdata   = we ? modelWdata(ctrl, wd) : 32'd0;
      timedOut = !(ackDelay >= 1 && ackDelay <= 16);
      waitExp  = timedOut ? 16 : ackDelay;
      stallCnt = stall ? 1 : 0;
      @(posedge clk); #1;
      checkOutput("req_rise", busIf.bus_req, 1'b1);
      checkOutput("bus_we", busIf.bus_we, we);
      checkOutput("bus_addr", busIf.bus_addr, eAddr);
      checkOutput("bus_be", {28'd0, busIf.bus_be}, {28'd0, eBe});
      if (we) checkOutput("bus_wdata", busIf.bus_wdata, eWdata);
      reqCnt = 0;
      stable = 1'b1;
      done   = 1'b0;
      for (int w = 1; w <= 40 && !done; w++) begin
        if (busIf.bus_req) reqCnt++;
        if (stall) stallCnt++;
        if (busIf.bus_addr !== eAddr || busIf.bus_be !== eBe || busIf.bus_we !== we) stable = 1'b0;
        if (w == ackDelay) busIf.bus_ack = 1'b1;
        @(posedge clk); #1;
        busIf.bus_ack = 1'b0;
        if (!stall) done = 1'b1;
      end
      checkOutput("reached_done", done, 1'b1);
      checkOutput("req_cycles", reqCnt, waitExp);
      checkOutput("stall_cycles", stallCnt, waitExp + 1);
      checkOutput("bus_stable", stable, 1'b1);
      checkOutput("done_req_low", busIf.bus_req, 1'b0);
      checkOutput("bus_err", busErr, timedOut);
      if (timedOut) expRd = 32'd0;
      else if (!we) expRd = modelLoad(ctrl, addr, rd);
      checkOutput("dm_data_rd", dmDataRd, expRd);
      memValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("err_pulse_end", busErr, 1'b0);
    end
  endtask

  initial begin
    int          r;
    int          dly;
    logic [31:0] a;

    clk      = 1'b0;
    rst      = 1'b1;
    memValid = 1'b0;
    dmWr     = 1'b0;
    dmCtrl   = 3'd0;
    aluRes   = 32'd0;
    dmDataWr = 32'd0;
    busIf.bus_rdata = 32'd0;
    busIf.bus_ack   = 1'b0;
    checks   = 0;
    errors   = 0;
    expRd    = 32'd0;

    #12;
    checkOutput("rst_req", busIf.bus_req, 1'b0);
    checkOutput("rst_addr", busIf.bus_addr, 32'd0);
    checkOutput("rst_rd", dmDataRd, 32'd0);
    checkOutput("rst_err", busErr, 1'b0);
    checkOutput("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 2);
    checkOutput("sb_rd_unchanged", dmDataRd, 32'd0);
    applyStimulus(1'b0, 3'b000, 32'h0000_1002, 32'h0, 32'h12F4_5678, 1);
    checkOutput("lb_value", dmDataRd, 32'hFFFF_FFF4);
    applyStimulus(1'b0, 3'b100, 32'h0000_1002, 32'h0, 32'h12F4_5678, 3);
    checkOutput("lbu_value", dmDataRd, 32'h0000_00F4);
    applyStimulus(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h12F4_5678, 1);
    checkOutput("lhu_value", dmDataRd, 32'h0000_12F4);
    applyStimulus(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h12F4_5678, 2);
    checkOutput("lw_value", dmDataRd, 32'h12F4_5678);
    applyStimulus(1'b0, 3'b001, 32'h0000_1001, 32'h0, 32'h12F4_5678, 1);
    checkOutput("lh_mis_value", dmDataRd, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 1);
    applyStimulus(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h12F4_5678, 1);
    checkOutput("ctrl011_value", dmDataRd, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1111_2222, 0);
    checkOutput("timeout_rd", dmDataRd, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'h3333_4444, 16);
    checkOutput("ack_on_last_cycle", dmDataRd, 32'h3333_4444);
    applyStimulus(1'b1, 3'b101, 32'h0000_2000, 32'h55AA, 32'h0, 1);

    busIf.bus_ack   = 1'b1;
    busIf.bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    busIf.bus_ack = 1'b0;
    checkOutput("idle_ack_ignored_rd", dmDataRd, expRd);
    checkOutput("idle_ack_ignored_req", busIf.bus_req, 1'b0);

    memValid = 1'b1;
    dmWr     = 1'b0;
    dmCtrl   = 3'b010;
    aluRes   = 32'h0000_3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("wait_req_before_rst", busIf.bus_req, 1'b1);
    rst      = 1'b1;
    memValid = 1'b0;
    #1;
    expRd = 32'd0;
    checkOutput("midrst_req", busIf.bus_req, 1'b0);
    checkOutput("midrst_be", {28'd0, busIf.bus_be}, 32'd0);
    checkOutput("midrst_addr", busIf.bus_addr, 32'd0);
    checkOutput("midrst_rd", dmDataRd, 32'd0);
    checkOutput("midrst_stall", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0BAD_F00D, 2);
    checkOutput("lw_after_rst", dmDataRd, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r == 0) dly = 0;
      else if (r == 1) dly = 16;
      else dly = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom, $urandom, dly);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
